// File: rtl/btn_pkg.sv
// Shared definitions for the display-board button scanner: the bit order of
// the 16-bit button vector and the scan sequencer state encoding.
package btn_pkg;

    localparam int NUM_BUTTONS = 16;

    // Bit positions inside the published button vector.
    localparam int BTN_BUTTON_B          = 15;
    localparam int BTN_BUTTON_A          = 14;
    localparam int BTN_BUTTON_Y          = 13;
    localparam int BTN_BUTTON_X          = 12;
    localparam int BTN_DPAD_UP           = 11;
    localparam int BTN_DPAD_DOWN         = 10;
    localparam int BTN_DPAD_LEFT         = 9;
    localparam int BTN_DPAD_RIGHT        = 8;
    localparam int BTN_DIALL_CLICK       = 7;
    localparam int BTN_DIALL_A           = 6;
    localparam int BTN_DIALL_B           = 5;
    localparam int BTN_DIALR_A           = 4;
    localparam int BTN_DIALR_B           = 3;
    localparam int BTN_DIALR_CLICK       = 2;
    localparam int BTN_DOOR_OPEN         = 1;
    localparam int BTN_TEMPERATURE_ALARM = 0;

    // Field order matches the shift register's MSB-first serial order.
    typedef struct packed {
        logic button_b;
        logic button_a;
        logic button_y;
        logic button_x;
        logic dpad_up;
        logic dpad_down;
        logic dpad_left;
        logic dpad_right;
        logic diall_click;
        logic diall_a;
        logic diall_b;
        logic dialr_a;
        logic dialr_b;
        logic dialr_click;
        logic door_open;
        logic temperature_alarm;
    } buttonsT;

    typedef enum logic [2:0] {
        S_GAP,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_UPDATE
    } scan_state_t;

endpackage

// File: rtl/button_debounce.sv
// One debounced button bit. Evaluated only when en is high (once per scan):
// the published state follows the sample after DEBOUNCE_SCANS consecutive
// disagreeing scans, with a one-cycle pressed/released pulse on the change.
module button_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sample,
    output logic state,
    output logic pressed,
    output logic released
);

    logic [3:0] cnt;

    // Count disagreeing scans; flip the state and pulse when the run is long enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            state    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= 1'b0;
            released <= 1'b0;
            if (en) begin
                if (sample == state) begin
                    cnt <= 4'd0;
                end else if (cnt == 4'(DEBOUNCE_SCANS - 1)) begin
                    state    <= sample;
                    cnt      <= 4'd0;
                    pressed  <= sample;
                    released <= ~sample;
                end else begin
                    cnt <= cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/button_scan_ctrl.sv
// Scan sequencer for the display-board 16-bit PISO button register: loads,
// shifts the bits in MSB first, then debounces every bit once per scan and
// publishes the stable vector with press/release pulses and scan_done.
module button_scan_ctrl
    import btn_pkg::*;
#(
    parameter int CLK_DIV        = 25,
    parameter int GAP_CYCLES     = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        shiftreg_clk,
    output logic        shiftreg_loadn,
    input  logic        shiftreg_out,
    output logic [15:0] buttons,
    output logic [15:0] pressed,
    output logic [15:0] released,
    output logic        scan_done
);

    // A zero gap still spends one cycle in GAP.
    localparam int GAP_LEN = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
    localparam int TMR_MAX = (GAP_LEN > CLK_DIV) ? GAP_LEN : CLK_DIV;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    scan_state_t            state, next_state;
    logic [TMR_W-1:0]       tmr;
    logic                   tmr_last;
    logic [3:0]             bit_idx;
    logic [NUM_BUTTONS-1:0] raw;
    logic [NUM_BUTTONS-1:0] raw_s;
    logic                   loadn_d, sclk_d, update_strobe;
    buttonsT                btn_vec;
    logic [NUM_BUTTONS-1:0] pressed_vec, released_vec;

    // Flags the final cycle of the current state's dwell time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        tmr_last = 1'b0;
        unique case (state)
            S_GAP:    tmr_last = (tmr == TMR_W'(GAP_LEN - 1));
            S_UPDATE: tmr_last = 1'b1;
            default:  tmr_last = (tmr == TMR_W'(CLK_DIV - 1));
        endcase
    end

    // State register plus dwell timer, bit index and raw sample capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: raw is reset too, so an aborted scan never leaks into a later one.
            state   <= S_GAP;
            tmr     <= '0;
            bit_idx <= 4'd0;
            raw     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from pre-edge values.
            state <= next_state;
            tmr   <= (next_state != state) ? '0 : tmr + TMR_W'(1);
            if (state == S_SHIFT_LO && tmr_last)
                raw[4'(NUM_BUTTONS - 1) - bit_idx] <= shiftreg_out;
            if (state == S_SHIFT_HI && tmr_last)
                bit_idx <= bit_idx + 4'd1;
        end
    end

    // Next-state sequencing of the load/shift/update/gap cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            S_GAP:      if (tmr_last) next_state = S_LOAD;
            S_LOAD:     if (tmr_last) next_state = S_SHIFT_LO;
            S_SHIFT_LO: if (tmr_last) next_state = S_SHIFT_HI;
            S_SHIFT_HI: if (tmr_last)
                            next_state = (bit_idx == 4'(NUM_BUTTONS - 1)) ? S_UPDATE : S_SHIFT_LO;
            S_UPDATE:   next_state = S_GAP;
            default:    next_state = S_GAP;
        endcase
    end

    // Pin levels and update strobe for the coming cycle, decoded from next_state.
    always_comb begin
        loadn_d       = (next_state != S_LOAD);
        sclk_d        = (next_state == S_SHIFT_HI);
        update_strobe = (next_state == S_UPDATE);
    end

    // Register pin drives and scan_done so outputs come straight from flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            shiftreg_loadn <= 1'b1;
            shiftreg_clk   <= 1'b0;
            scan_done      <= 1'b0;
        end else begin
            shiftreg_loadn <= loadn_d;
            shiftreg_clk   <= sclk_d;
            scan_done      <= update_strobe;
        end
    end

    // Normalise polarity so 1 always means pressed before debouncing.
    assign raw_s = raw ^ {NUM_BUTTONS{ACTIVE_LOW}};

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_debounce
        button_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_debounce (
            .clk     (clk),
            .rst     (rst),
            .en      (update_strobe),
            .sample  (raw_s[i]),
            .state   (btn_vec[i]),
            .pressed (pressed_vec[i]),
            .released(released_vec[i])
        );
    end

    assign buttons  = btn_vec;
    assign pressed  = pressed_vec;
    assign released = released_vec;

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Self-checking bench for button_scan_ctrl: models the external shift
// register, predicts pin timing and debounced outputs from scan arithmetic,
// and compares every cycle, plus literal checks of key scenarios.
module tb_button_scan_ctrl;
    import btn_pkg::*;

    localparam int L      = 2;
    localparam int GAP    = 4;
    localparam int DEB    = 4;
    localparam int G      = (GAP > 0) ? GAP : 1;
    localparam int UPD    = G + 33 * L;
    localparam int PERIOD = UPD + 1;
    localparam logic [15:0] PINS2 = 16'hA5C3;

    logic        CLOCK_50 = 1'b0;
    logic        rst = 1'b1;
    logic        sclk, loadn, sout, done;
    logic [15:0] buttons, pressed, released;
    logic        sclk2, loadn2, sout2, done2;
    logic [15:0] buttons2, pressed2, released2;

    logic [15:0] pins  = 16'hFFFF;
    logic [15:0] pins2 = PINS2;
    logic [15:0] sreg  = 16'h0;
    logic [15:0] sreg2 = 16'h0;
    logic        sclk_q = 1'b0, sclk2_q = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    button_scan_ctrl #(.CLK_DIV(L), .GAP_CYCLES(GAP), .DEBOUNCE_SCANS(DEB), .ACTIVE_LOW(1'b1)) dut (
        .clk(CLOCK_50), .rst(rst), .shiftreg_clk(sclk), .shiftreg_loadn(loadn),
        .shiftreg_out(sout), .buttons(buttons), .pressed(pressed),
        .released(released), .scan_done(done));

    button_scan_ctrl #(.CLK_DIV(L), .GAP_CYCLES(GAP), .DEBOUNCE_SCANS(DEB), .ACTIVE_LOW(1'b0)) dut2 (
        .clk(CLOCK_50), .rst(rst), .shiftreg_clk(sclk2), .shiftreg_loadn(loadn2),
        .shiftreg_out(sout2), .buttons(buttons2), .pressed(pressed2),
        .released(released2), .scan_done(done2));

    // External PISO register models: parallel load while loadn low, shift on clk rise.
    assign sout  = sreg[15];
    assign sout2 = sreg2[15];
    always @(posedge CLOCK_50) begin
        if (!loadn) sreg <= pins;
        else if (sclk && !sclk_q) sreg <= {sreg[14:0], 1'b0};
        sclk_q <= sclk;
        if (!loadn2) sreg2 <= pins2;
        else if (sclk2 && !sclk2_q) sreg2 <= {sreg2[14:0], 1'b0};
        sclk2_q <= sclk2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Cycle index since the last reset edge.
    int n = 0;
    bit active = 1'b0;
    always @(posedge CLOCK_50) begin
        if (rst) begin
            n <= 0;
            active <= 1'b1;
        end else begin
            n <= n + 1;
        end
    end

    // Reference model: scan timing from arithmetic, debounce as run length per bit.
    int          p, rises, lo_cnt;
    int          run_m [16];
    logic [15:0] btn_m, scan_vec, s_m, exp_p, exp_r;
    logic        exp_loadn, exp_sclk, prev_sclk;
    always @(negedge CLOCK_50) begin
        if (active) begin
            p = n % PERIOD;
            if (n == 0) begin
                btn_m = 16'h0;
                for (int i = 0; i < 16; i++) run_m[i] = 0;
            end
            if (p == 0) begin
                rises = 0;
                lo_cnt = 0;
                prev_sclk = 1'b0;
            end
            if (p == G) scan_vec = pins;
            exp_p = 16'h0;
            exp_r = 16'h0;
            if (p == UPD) begin
                s_m = ~scan_vec;
                for (int i = 0; i < 16; i++) begin
                    if (s_m[i] == btn_m[i]) run_m[i] = 0;
                    else begin
                        run_m[i]++;
                        if (run_m[i] == DEB) begin
                            run_m[i] = 0;
                            btn_m[i] = s_m[i];
                            if (s_m[i]) exp_p[i] = 1'b1;
                            else        exp_r[i] = 1'b1;
                        end
                    end
                end
            end
            exp_loadn = !(p >= G && p < G + L);
            exp_sclk  = (p >= G + L && p < UPD) && ((((p - G - L) / L) % 2) == 1);
            check("cycle {loadn,sclk,done,buttons,pressed,released}",
                  64'({loadn, sclk, done, buttons, pressed, released}),
                  64'({exp_loadn, exp_sclk, (p == UPD), btn_m, exp_p, exp_r}));
            if (sclk && !prev_sclk) rises++;
            if (!loadn) lo_cnt++;
            prev_sclk = sclk;
            if (p == UPD) begin
                check("sclk_rises_per_scan", 64'(rises), 64'd16);
                check("loadn_low_cycles", 64'(lo_cnt), 64'(L));
            end
        end
    end

    task automatic scans(input int k);
        repeat (k * PERIOD) @(negedge CLOCK_50);
    endtask

    int idx;
    initial begin
        rst = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        rst = 1'b0;
        check("reset_buttons", 64'(buttons), 64'h0);
        check("reset_pins", 64'({loadn, sclk}), 64'b10);

        // Idle scans with every raw bit high.
        repeat (UPD) @(negedge CLOCK_50);
        check("scan1_done", 64'(done), 64'd1);
        scans(2);
        check("idle_buttons", 64'(buttons), 64'h0);
        check("dut2_scan3_buttons", 64'(buttons2), 64'h0);

        // Hold dialr_click pressed.
        pins[BTN_DIALR_CLICK] = 1'b0;
        scans(1);
        check("dut2_scan4_pressed", 64'(pressed2), 64'(PINS2));
        check("dut2_serial_order", 64'(buttons2), 64'(PINS2));
        scans(2);
        check("bit2_not_yet", 64'(buttons), 64'h0);
        scans(1);
        check("bit2_buttons", 64'(buttons), 64'h0004);
        check("bit2_pressed", 64'(pressed), 64'h0004);
        pins[BTN_DIALR_CLICK] = 1'b1;
        @(negedge CLOCK_50);
        check("bit2_pressed_one_cycle", 64'(pressed), 64'h0);
        repeat (UPD) @(negedge CLOCK_50);
        scans(3);
        check("bit2_released", 64'(released), 64'h0004);
        check("bit2_release_buttons", 64'(buttons), 64'h0);
        check("bit2_release_no_press", 64'(pressed), 64'h0);

        // Bit 9 alternating every scan never settles.
        for (int k = 0; k < 20; k++) begin
            pins[BTN_DPAD_LEFT] = ~pins[BTN_DPAD_LEFT];
            scans(1);
        end
        pins[BTN_DPAD_LEFT] = 1'b1;
        check("bit9_alternating", 64'(buttons[BTN_DPAD_LEFT]), 64'h0);

        // Both end bits together.
        pins = ~16'h8001;
        scans(4);
        check("ends_pressed", 64'(pressed), 64'h8001);
        check("ends_buttons", 64'(buttons), 64'h8001);

        // Randomised held patterns and single-bit flips.
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 2) == 0) pins = 16'($urandom);
            else if ($urandom_range(0, 1) == 0) begin
                idx = $urandom_range(0, 15);
                pins[idx] = ~pins[idx];
            end
            scans(1);
        end

        // Reset during SHIFT_HI of bit 7.
        repeat (G + L + 7 * 2 * L + L + 1 + (PERIOD - UPD)) @(negedge CLOCK_50);
        pins = ~16'h0F0F;
        rst = 1'b1;
        @(negedge CLOCK_50);
        rst = 1'b0;
        check("midreset_pins", 64'({loadn, sclk, done}), 64'b100);
        check("midreset_buttons", 64'(buttons), 64'h0);
        check("midreset_pulses", 64'({pressed, released}), 64'h0);
        check("midreset_dut2", 64'(buttons2), 64'h0);
        repeat (UPD) @(negedge CLOCK_50);
        scans(2);
        check("after_reset_scan3", 64'(buttons), 64'h0);
        scans(1);
        check("after_reset_buttons", 64'(buttons), 64'h0F0F);
        check("after_reset_pressed", 64'(pressed), 64'h0F0F);
        check("after_reset_dut2", 64'(buttons2), 64'(PINS2));
        scans(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
